// File: rtl/countdown_pkg.sv
// Shared types and default sizing for the countdown sequencer and its helpers.
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int N_DEF   = 4;
  localparam int DIV_DEF = 4;

endpackage

// File: rtl/btn_edge_sync.sv
// Brings a raw asynchronous push-button into the clk domain and emits a single
// one-cycle pulse per press (rising edge of the synchronized level).
module btn_edge_sync
  import countdown_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // s1 is the metastability catcher; edge detection uses only s2/s3.
  assign pulse = s2 & ~s3;

endmodule

// File: rtl/countdown_sequencer.sv
// Countdown control: loads num, emits prescaled dec strobes down to zero, flags done.
//   state | meaning
//   IDLE  | after reset, waiting for the first start press
//   RUN   | prescaler counting, dec issued every DIV cycles
//   PAUSE | prescaler and count frozen until pause pressed again
//   DONE  | count is zero; reloads on start, or every cycle with auto_reload
module countdown_sequencer
  import countdown_pkg::*;
#(
  parameter int N   = N_DEF,
  parameter int DIV = DIV_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_btn,
  input  logic         pause_btn,
  input  logic [N-1:0] num,
  input  logic         auto_reload,
  output logic         ld,
  output logic         dec,
  output logic [N-1:0] count,
  output logic         busy,
  output logic         done
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PS_LAST = PW'(DIV - 1);

  state_t        state, state_nx;
  logic [PW-1:0] presc, presc_nx;
  logic [N-1:0]  count_nx;
  logic          ld_nx, dec_nx;
  logic          start_ev, pause_ev;
  logic          load, advance;

  btn_edge_sync u_start_sync (
    .clk   (clk),
    .rst   (rst),
    .btn   (start_btn),
    .pulse (start_ev)
  );

  btn_edge_sync u_pause_sync (
    .clk   (clk),
    .rst   (rst),
    .btn   (pause_btn),
    .pulse (pause_ev)
  );

  always_comb begin
    state_nx = state;
    presc_nx = presc;
    count_nx = count;
    ld_nx    = 1'b0;
    dec_nx   = 1'b0;
    load     = 1'b0;
    advance  = 1'b0;

    case (state)
      IDLE: begin
        if (start_ev) load = 1'b1;
      end
      RUN: begin
        if (start_ev)      load = 1'b1;
        else if (pause_ev) state_nx = PAUSE;
        else               advance = 1'b1;
      end
      PAUSE: begin
        // The resume edge counts as a run cycle, so the frozen phase carries on.
        if (start_ev) begin
          load = 1'b1;
        end else if (pause_ev) begin
          state_nx = RUN;
          advance  = 1'b1;
        end
      end
      DONE: begin
        if (start_ev || auto_reload) load = 1'b1;
      end
      default: state_nx = IDLE;
    endcase

    if (load) begin
      count_nx = num;
      presc_nx = '0;
      ld_nx    = 1'b1;
      state_nx = (num == '0) ? DONE : RUN;
    end else if (advance) begin
      if (presc == PS_LAST) begin
        presc_nx = '0;
        if (count != '0) begin
          count_nx = count - N'(1);
          dec_nx   = 1'b1;
          if (count == N'(1)) state_nx = DONE;
        end
      end else begin
        presc_nx = presc + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      presc <= '0;
      count <= '0;
      ld    <= 1'b0;
      dec   <= 1'b0;
    end else begin
      state <= state_nx;
      presc <= presc_nx;
      count <= count_nx;
      ld    <= ld_nx;
      dec   <= dec_nx;
    end
  end

  assign busy = (state == RUN) || (state == PAUSE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_countdown_sequencer.sv
// Directed bench for countdown_sequencer: expected output snapshots are queued
// per cycle as stimulus is applied and compared after each rising edge.
module tb_countdown_sequencer;
  import countdown_pkg::*;

  localparam int N   = 4;
  localparam int DIV = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start_btn = 1'b0;
  logic         pause_btn = 1'b0;
  logic         auto_reload = 1'b0;
  logic [N-1:0] num = '0;
  logic         ld, dec, busy, done;
  logic [N-1:0] count;

  typedef struct {
    string      tag;
    logic [7:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  countdown_sequencer #(.N(N), .DIV(DIV)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_btn   (start_btn),
    .pause_btn   (pause_btn),
    .num         (num),
    .auto_reload (auto_reload),
    .ld          (ld),
    .dec         (dec),
    .count       (count),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input bit l, input bit d, input int c,
                      input bit b, input bit dn);
    exp_t e;
    e.tag = tag;
    e.v   = {l, d, N'(c), b, dn};
    sb.push_back(e);
  endtask

  task automatic step_check();
    exp_t       e;
    logic [7:0] obs;
    @(posedge clk);
    #1;
    obs = {ld, dec, count, busy, done};
    e = sb.pop_front();
    n_assert++;
    assert (obs === e.v) else begin
      n_fail++;
      $error("FAIL %s: observed ld=%0b dec=%0b count=%0d busy=%0b done=%0b, expected ld=%0b dec=%0b count=%0d busy=%0b done=%0b",
             e.tag, obs[7], obs[6], obs[5:2], obs[1], obs[0],
             e.v[7], e.v[6], e.v[5:2], e.v[1], e.v[0]);
    end
  endtask

  // Two cycles of a button press/release while the DUT sits in a steady state;
  // the event then acts on the following edge.
  task automatic press(input string tag, input bit s, input bit p, input int c,
                       input bit b, input bit dn);
    start_btn = s;
    pause_btn = p;
    push(tag, 1'b0, 1'b0, c, b, dn);
    step_check();
    start_btn = 1'b0;
    pause_btn = 1'b0;
    push(tag, 1'b0, 1'b0, c, b, dn);
    step_check();
  endtask

  initial begin
    // power-on reset
    rst = 1'b0;
    repeat (2) begin
      push("reset", 0, 0, 0, 0, 0);
      step_check();
    end
    rst = 1'b1;

    // zero load from IDLE, then auto-reload of zero
    num = 4'd0;
    press("zero_pre", 1, 0, 0, 0, 0);
    for (int k = 0; k <= 6; k++) begin
      push("zero_load", k == 0, 0, 0, 0, 1);
      step_check();
    end
    auto_reload = 1'b1;
    push("zero_autoreload", 1, 0, 0, 0, 1);
    step_check();
    push("zero_autoreload", 1, 0, 0, 0, 1);
    step_check();
    auto_reload = 1'b0;
    push("zero_autoreload_off", 0, 0, 0, 0, 1);
    step_check();

    // basic countdown from 3
    num = 4'd3;
    press("basic_pre", 1, 0, 0, 0, 1);
    for (int k = 0; k <= 16; k++) begin
      push("basic", k == 0, (k > 0) && (k <= 12) && (k % 4 == 0),
           (k >= 12) ? 0 : 3 - k / 4, k < 12, k >= 12);
      step_check();
    end

    // pause at E+6, hold, resume at E+16, then reset mid-run at count 3
    num = 4'd5;
    press("pause_pre", 1, 0, 0, 0, 1);
    for (int k = 0; k <= 19; k++) begin
      push("pause_resume", k == 0, (k == 4) || (k == 18),
           (k < 4) ? 5 : (k < 18) ? 4 : 3, 1, 0);
      step_check();
      if (k == 3 || k == 13) pause_btn = 1'b1;
      if (k == 4 || k == 14) pause_btn = 1'b0;
    end
    rst = 1'b0;
    push("reset_mid_run", 0, 0, 0, 0, 0);
    step_check();
    rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      push("idle_after_reset", 0, 0, 0, 0, 0);
      step_check();
    end

    // auto-reload of 2: two full cycles without another start
    num = 4'd2;
    auto_reload = 1'b1;
    press("ar_pre", 1, 0, 0, 0, 0);
    for (int k = 0; k <= 18; k++) begin
      int j;
      j = k % 9;
      push("auto_reload", j == 0, (j == 4) || (j == 8),
           (j < 4) ? 2 : (j < 8) ? 1 : 0, j != 8, j == 8);
      step_check();
    end
    rst = 1'b0;
    push("reset_ar", 0, 0, 0, 0, 0);
    step_check();
    rst = 1'b1;
    auto_reload = 1'b0;

    // start+pause together at count 7, long start hold, pause on a tick edge
    num = 4'd9;
    press("prio_pre", 1, 0, 0, 0, 0);
    for (int k = 0; k <= 44; k++) begin
      if (k < 41) begin
        int l;
        int d;
        l = (k >= 17) ? 17 : (k >= 10) ? 10 : 0;
        d = k - l;
        push("priority_restart", d == 0, (d > 0) && (d % 4 == 0), 9 - d / 4, 1, 0);
      end else begin
        push("pause_on_tick", 0, 0, 4, 1, 0);
      end
      step_check();
      if (k == 7)  begin start_btn = 1'b1; pause_btn = 1'b1; end
      if (k == 8)  begin start_btn = 1'b0; pause_btn = 1'b0; end
      if (k == 14) start_btn = 1'b1;
      if (k == 34) start_btn = 1'b0;
      if (k == 38) pause_btn = 1'b1;
      if (k == 39) pause_btn = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/countdown_sequencer.md
Name: countdown_sequencer

Overview:
- Control block for the N-bit down-counter / dual 7-segment display datapath.
- Turns two raw push-buttons (start, pause) into a sequenced countdown.
- Loads a start value, then issues one-cycle `dec` strobes at a fixed prescaled rate until the count reaches zero, and flags completion.
- Owns the authoritative count; the display datapath consumes `ld`, `dec` and `count`.

Parameters:
- N, 4, width of the count and load value.
- DIV, 4, clock cycles per decrement tick (DIV >= 2); the prescaler is $clog2(DIV) bits.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-low reset (sampled on clk rising edge; 0 = reset)
- start_btn  in  1  raw start button, active-high, asynchronous to clk
- pause_btn  in  1  raw pause/resume button, active-high, asynchronous to clk
- num  in  N  load value, sampled only when a load occurs
- auto_reload  in  1  1 = reload `num` and restart automatically on reaching zero
- ld  out  1  one-cycle pulse, the cycle after `count` is loaded from `num`
- dec  out  1  one-cycle pulse, the cycle after `count` is decremented
- count  out  N  current count value, registered
- busy  out  1  high in RUN or PAUSE
- done  out  1  high in DONE

Behaviour:
- Reset (rst==0 at a clk edge):
  - State = IDLE; count, ld, dec, busy, done all 0.
  - Prescaler and all synchronizer flops cleared.
  - Applies even when another event occurs in the same cycle (reset dominates).
- Button conditioning (per button):
  - Three flops: s1<=btn, s2<=s1, s3<=s2; event = s2 & ~s3.
  - A button first sampled high at edge t takes effect at edge t+2.
  - Holding a button generates exactly one event; a new event needs a release and re-press.
- All outputs are registered. `ld` and `dec` are never high in the same cycle.
- States: IDLE, RUN, PAUSE, DONE.
- Load action:
  - count<=num, prescaler<=0, ld=1 in the next cycle.
  - If num==0, go to DONE; otherwise go to RUN.
- IDLE:
  - Start event -> load action.
  - Pause event ignored.
- RUN:
  - Prescaler increments each cycle.
  - When prescaler==DIV-1: prescaler<=0, count<=count-1, dec=1 next cycle.
  - If that decrement takes count from 1 to 0, go to DONE on the same edge.
  - Start event -> load action (restart); pending tick discarded.
  - Pause event -> PAUSE; prescaler and count frozen.
  - Start and pause events in the same cycle: start wins.
  - A tick coinciding with a pause event: pause wins; no decrement.
- PAUSE:
  - Pause event -> RUN; prescaler resumes from its held value.
  - Start event -> load action.
  - Start and pause in the same cycle: start wins.
- DONE:
  - done=1, count=0.
  - If auto_reload==1: load action on the next edge. If num==0 again, stay in DONE; ld still pulses.
  - Otherwise wait for a start event -> load action.
  - Pause event ignored.
- Arithmetic:
  - count never wraps below 0.
  - count is unsigned N bits; num=2^N-1 is supported.

Decomposition:
- Shared package `countdown_pkg`:
  - typedef enum logic [1:0] state_t {IDLE, RUN, PAUSE, DONE}.
  - localparam default N and DIV values.
- One sub-module: `btn_edge_sync` (3-flop synchronizer plus rising-edge detector, same clk/rst). Instantiated twice.
- FSM, prescaler and count register live in the top module.

Test Plan:
(In all scenarios N=4, DIV=4, and E is the edge at which the start event acts.)
- Basic countdown:
  - Stimulus: num=3, auto_reload=0, start pulse.
  - Required: ld=1 after E; count=3; dec pulses after E+4, E+8, E+12; count 2,1,0; done=1 and busy=0 after E+12, held until the next start.
- Pause/resume:
  - Stimulus: num=5, start; pause event acting at E+6; hold 10 cycles; pause again.
  - Required: count stays 4 and no dec while paused; next dec arrives 2 cycles after the resume event acts (prescaler held at 1).
- Zero load:
  - Stimulus: num=0, start.
  - Required: ld=1 and done=1 after E; no dec ever; busy=0.
- Auto-reload:
  - Stimulus: num=2, auto_reload=1.
  - Required: reaches 0 after E+8; done=1 for one cycle; ld pulse one cycle later; count=2; decrement cycle repeats with no start press.
- Priority and restart:
  - Stimulus: start and pause events in the same cycle during RUN at count=7 with num=9.
  - Required: count reloads to 9, state RUN, ld=1.
  - Stimulus: start held for 20 cycles.
  - Required: only one ld pulse.
- Reset mid-run:
  - Stimulus: rst=0 for one edge at count=3 in RUN.
  - Required: count=0, dec=ld=busy=done=0 after that edge; IDLE; no dec until a new start.
